// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with next-PC select, exception redirect and return-address stack
//
// Purpose:
//   Holds the PC of the multi-cycle MIPS core. It selects the next PC
//   (sequential, branch, jump, register jump, eret) and redirects to the
//   exception vector while capturing EPC. It also keeps a small circular
//   return-address stack that the controller uses to predict jr $ra targets.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   PCWr                PC write enable; low = stall (PC and RAS hold)
//   NPCOp[2:0]          0 SEQ, 1 BR, 2 J, 3 JR, 4 ERET, 5-7 SEQ
//   br_taken            branch condition, used for BR only
//   imm16               branch offset in words (sign-extended)
//   j_index             26-bit jump index
//   jr_target           register jump target (low two bits dropped)
//   exc_req             exception request; wins over PCWr and NPCOp
//   ras_push, ras_pop   RAS push of PC+4 / pop
//   PC, PC_plus4        current PC and PC+4
//   EPC                 PC captured on the last exception
//   ras_top             newest RAS entry, 0 when empty
//   ras_empty, ras_full RAS occupancy flags

module pc_unit #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180),
   parameter int unsigned      RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             PCWr,
   input  logic [2:0]       NPCOp,
   input  logic             br_taken,
   input  logic [15:0]      imm16,
   input  logic [25:0]      j_index,
   input  logic [WIDTH-1:0] jr_target,
   input  logic             exc_req,
   input  logic             ras_push,
   input  logic             ras_pop,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] PC_plus4,
   output logic [WIDTH-1:0] EPC,
   output logic [WIDTH-1:0] ras_top,
   output logic             ras_empty,
   output logic             ras_full
);

   localparam logic [2:0] NPC_SEQ  = 3'd0;
   localparam logic [2:0] NPC_BR   = 3'd1;
   localparam logic [2:0] NPC_J    = 3'd2;
   localparam logic [2:0] NPC_JR   = 3'd3;
   localparam logic [2:0] NPC_ERET = 3'd4;

   localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   // One extra bit so the count can represent RAS_DEPTH itself.
   localparam int unsigned CW = PW + 1;

   localparam logic [CW-1:0]    CNT_FULL   = CW'(RAS_DEPTH);
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
   localparam logic [WIDTH-1:0] RESET_PC   = RESET_VEC & ALIGN_MASK;
   localparam logic [WIDTH-1:0] EXC_PC     = EXC_VEC & ALIGN_MASK;

   generate
      if (WIDTH < 32) begin : g_bad_width
         $error("pc_unit: WIDTH must be at least 32");
      end
      if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("pc_unit: RAS_DEPTH must be a power of two and at least 2");
      end
   endgenerate

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_epc;
   logic [WIDTH-1:0] r_ras [RAS_DEPTH];
   logic [PW-1:0]    r_wp;
   logic [CW-1:0]    r_cnt;

   // ------------------------------------------------------------------
   // Next-PC selection
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] w_pc_plus4;
   logic [WIDTH-1:0] w_br_off;
   logic [WIDTH-1:0] w_br_target;
   logic [WIDTH-1:0] w_j_target;
   logic [WIDTH-1:0] w_jr_target;
   logic [WIDTH-1:0] w_npc;

   assign w_pc_plus4  = r_pc + WIDTH'(4);
   assign w_br_off    = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
   assign w_br_target = w_pc_plus4 + w_br_off;
   // The jump keeps the region bits of the delay-slot address, i.e. PC+4.
   assign w_j_target  = {w_pc_plus4[WIDTH-1:28], j_index, 2'b00};
   assign w_jr_target = jr_target & ALIGN_MASK;

   always_comb begin
      w_npc = w_pc_plus4;
      case (NPCOp)
         NPC_SEQ:  w_npc = w_pc_plus4;
         NPC_BR:   w_npc = br_taken ? w_br_target : w_pc_plus4;
         NPC_J:    w_npc = w_j_target;
         NPC_JR:   w_npc = w_jr_target;
         NPC_ERET: w_npc = r_epc;
         default:  w_npc = w_pc_plus4;
      endcase
   end

   // ------------------------------------------------------------------
   // PC / EPC registers; an exception outranks everything but reset
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc  <= RESET_PC;
         r_epc <= '0;
      end else if (exc_req) begin
         r_pc  <= EXC_PC;
         r_epc <= r_pc;
      end else if (PCWr) begin
         r_pc  <= w_npc;
      end
   end

   // ------------------------------------------------------------------
   // Return-address stack
   // ------------------------------------------------------------------
   logic          w_ras_we;
   logic          w_do_push;
   logic          w_do_pop;
   logic          w_nonempty;
   logic [PW-1:0] w_wp_m1;

   // Only a committed, non-excepting PC update may move the stack.
   assign w_ras_we   = PCWr & ~exc_req;
   assign w_do_push  = w_ras_we & ras_push;
   assign w_do_pop   = w_ras_we & ras_pop;
   assign w_nonempty = (r_cnt != '0);
   assign w_wp_m1    = r_wp - PW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(RAS_DEPTH); i++) begin
            r_ras[i] <= '0;
         end
         r_wp  <= '0;
         r_cnt <= '0;
      end else if (w_do_push && w_do_pop && w_nonempty) begin
         // jalr-style replace: swap the top entry, depth unchanged.
         r_ras[w_wp_m1] <= w_pc_plus4;
      end else if (w_do_push) begin
         // Also covers push+pop on an empty stack. When full, the
         // pointer wraps onto the oldest entry and the count saturates.
         r_ras[r_wp] <= w_pc_plus4;
         r_wp        <= r_wp + PW'(1);
         if (r_cnt != CNT_FULL) begin
            r_cnt <= r_cnt + CW'(1);
         end
      end else if (w_do_pop && w_nonempty) begin
         r_wp  <= w_wp_m1;
         r_cnt <= r_cnt - CW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign PC        = r_pc;
   assign PC_plus4  = w_pc_plus4;
   assign EPC       = r_epc;
   assign ras_top   = w_nonempty ? r_ras[w_wp_m1] : '0;
   assign ras_empty = ~w_nonempty;
   assign ras_full  = (r_cnt == CNT_FULL);

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed table-driven bench for pc_unit

module tb_pc_unit;

   logic        clk;
   logic        rst_n;
   logic        PCWr;
   logic [2:0]  NPCOp;
   logic        br_taken;
   logic [15:0] imm16;
   logic [25:0] j_index;
   logic [31:0] jr_target;
   logic        exc_req;
   logic        ras_push;
   logic        ras_pop;
   logic [31:0] PC;
   logic [31:0] PC_plus4;
   logic [31:0] EPC;
   logic [31:0] ras_top;
   logic        ras_empty;
   logic        ras_full;

   pc_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .PCWr      (PCWr),
      .NPCOp     (NPCOp),
      .br_taken  (br_taken),
      .imm16     (imm16),
      .j_index   (j_index),
      .jr_target (jr_target),
      .exc_req   (exc_req),
      .ras_push  (ras_push),
      .ras_pop   (ras_pop),
      .PC        (PC),
      .PC_plus4  (PC_plus4),
      .EPC       (EPC),
      .ras_top   (ras_top),
      .ras_empty (ras_empty),
      .ras_full  (ras_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        pcwr;
      logic [2:0]  op;
      logic        brt;
      logic [15:0] imm;
      logic [25:0] jidx;
      logic [31:0] jrt;
      logic        exc;
      logic        push;
      logic        pop;
      logic [31:0] e_pc;
      logic [31:0] e_epc;
      logic [31:0] e_top;
      logic        e_empty;
      logic        e_full;
   } vec_t;

   localparam int NVEC = 39;
   vec_t tv [NVEC];

   int n_cmp = 0;
   int n_err = 0;

   function automatic vec_t mk(input logic pcwr, input logic [2:0] op, input logic brt,
                               input logic [15:0] imm, input logic [25:0] jidx,
                               input logic [31:0] jrt, input logic exc, input logic push,
                               input logic pop, input logic [31:0] e_pc, input logic [31:0] e_epc,
                               input logic [31:0] e_top, input logic e_empty, input logic e_full);
      vec_t v;
      v.pcwr = pcwr; v.op = op; v.brt = brt; v.imm = imm; v.jidx = jidx; v.jrt = jrt;
      v.exc = exc; v.push = push; v.pop = pop;
      v.e_pc = e_pc; v.e_epc = e_epc; v.e_top = e_top; v.e_empty = e_empty; v.e_full = e_full;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic [31:0] e_pc, input logic [31:0] e_epc,
                          input logic [31:0] e_top, input logic e_empty, input logic e_full);
      chk("PC", idx, PC, e_pc);
      chk("PC_plus4", idx, PC_plus4, e_pc + 32'd4);
      chk("EPC", idx, EPC, e_epc);
      chk("ras_top", idx, ras_top, e_top);
      chk("ras_empty", idx, {31'd0, ras_empty}, {31'd0, e_empty});
      chk("ras_full", idx, {31'd0, ras_full}, {31'd0, e_full});
   endtask

   task automatic drive(input vec_t v);
      PCWr = v.pcwr; NPCOp = v.op; br_taken = v.brt; imm16 = v.imm; j_index = v.jidx;
      jr_target = v.jrt; exc_req = v.exc; ras_push = v.push; ras_pop = v.pop;
   endtask

   initial begin
      //            pcwr op brt imm       jidx          jrt           exc psh pop  PC            EPC           top           emp full
      tv[0]  = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        0, 0, 0, 32'h0000_3004, 32'h0,        32'h0,        1, 0);
      tv[1]  = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        0, 0, 0, 32'h0000_3008, 32'h0,        32'h0,        1, 0);
      tv[2]  = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        0, 0, 0, 32'h0000_300C, 32'h0,        32'h0,        1, 0);
      tv[3]  = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        0, 0, 0, 32'h0000_3010, 32'h0,        32'h0,        1, 0);
      tv[4]  = mk(1, 1, 1, 16'hFFFC, 26'h0,       32'h0,        0, 0, 0, 32'h0000_3004, 32'h0,        32'h0,        1, 0);
      tv[5]  = mk(1, 3, 0, 16'h0,    26'h0,       32'h0000_3010,0, 0, 0, 32'h0000_3010, 32'h0,        32'h0,        1, 0);
      tv[6]  = mk(1, 1, 0, 16'hFFFC, 26'h0,       32'h0,        0, 0, 0, 32'h0000_3014, 32'h0,        32'h0,        1, 0);
      tv[7]  = mk(1, 3, 0, 16'h0,    26'h0,       32'h0000_3000,0, 0, 0, 32'h0000_3000, 32'h0,        32'h0,        1, 0);
      tv[8]  = mk(1, 2, 0, 16'h0,    26'h0000C10, 32'h0,        0, 0, 0, 32'h0000_3040, 32'h0,        32'h0,        1, 0);
      tv[9]  = mk(1, 3, 0, 16'h0,    26'h0,       32'h0000_3103,0, 0, 0, 32'h0000_3100, 32'h0,        32'h0,        1, 0);
      tv[10] = mk(1, 3, 0, 16'h0,    26'h0,       32'h0000_3020,0, 0, 0, 32'h0000_3020, 32'h0,        32'h0,        1, 0);
      tv[11] = mk(0, 0, 0, 16'h0,    26'h0,       32'h0,        1, 0, 0, 32'h0000_4180, 32'h0000_3020,32'h0,        1, 0);
      tv[12] = mk(1, 4, 0, 16'h0,    26'h0,       32'h0,        0, 0, 0, 32'h0000_3020, 32'h0000_3020,32'h0,        1, 0);
      tv[13] = mk(0, 2, 0, 16'h0,    26'h3FFFFFF, 32'h0,        0, 0, 0, 32'h0000_3020, 32'h0000_3020,32'h0,        1, 0);
      tv[14] = mk(1, 3, 0, 16'h0,    26'h0,       32'h0000_5000,1, 1, 0, 32'h0000_4180, 32'h0000_3020,32'h0,        1, 0);
      tv[15] = mk(1, 5, 0, 16'h0,    26'h0,       32'h0,        0, 0, 0, 32'h0000_4184, 32'h0000_3020,32'h0,        1, 0);
      tv[16] = mk(1, 1, 1, 16'h0002, 26'h0,       32'h0,        0, 0, 0, 32'h0000_4190, 32'h0000_3020,32'h0,        1, 0);
      tv[17] = mk(1, 3, 0, 16'h0,    26'h0,       32'h0000_3000,0, 0, 0, 32'h0000_3000, 32'h0000_3020,32'h0,        1, 0);
      tv[18] = mk(1, 3, 0, 16'h0,    26'h0,       32'h0000_3010,0, 1, 0, 32'h0000_3010, 32'h0000_3020,32'h0000_3004,0, 0);
      tv[19] = mk(1, 3, 0, 16'h0,    26'h0,       32'h0000_3020,0, 1, 0, 32'h0000_3020, 32'h0000_3020,32'h0000_3014,0, 0);
      tv[20] = mk(1, 3, 0, 16'h0,    26'h0,       32'h0000_3030,0, 1, 0, 32'h0000_3030, 32'h0000_3020,32'h0000_3024,0, 0);
      tv[21] = mk(1, 3, 0, 16'h0,    26'h0,       32'h0000_3040,0, 1, 0, 32'h0000_3040, 32'h0000_3020,32'h0000_3034,0, 1);
      tv[22] = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        0, 1, 0, 32'h0000_3044, 32'h0000_3020,32'h0000_3044,0, 1);
      tv[23] = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        0, 0, 1, 32'h0000_3048, 32'h0000_3020,32'h0000_3034,0, 0);
      tv[24] = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        0, 0, 1, 32'h0000_304C, 32'h0000_3020,32'h0000_3024,0, 0);
      tv[25] = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        0, 0, 1, 32'h0000_3050, 32'h0000_3020,32'h0000_3014,0, 0);
      tv[26] = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        0, 0, 1, 32'h0000_3054, 32'h0000_3020,32'h0,        1, 0);
      tv[27] = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        0, 0, 1, 32'h0000_3058, 32'h0000_3020,32'h0,        1, 0);
      tv[28] = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        0, 1, 1, 32'h0000_305C, 32'h0000_3020,32'h0000_305C,0, 0);
      tv[29] = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        0, 1, 0, 32'h0000_3060, 32'h0000_3020,32'h0000_3060,0, 0);
      tv[30] = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        0, 1, 1, 32'h0000_3064, 32'h0000_3020,32'h0000_3064,0, 0);
      tv[31] = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        0, 0, 1, 32'h0000_3068, 32'h0000_3020,32'h0000_305C,0, 0);
      tv[32] = mk(0, 0, 0, 16'h0,    26'h0,       32'h0,        0, 1, 0, 32'h0000_3068, 32'h0000_3020,32'h0000_305C,0, 0);
      tv[33] = mk(0, 0, 0, 16'h0,    26'h0,       32'h0,        0, 1, 0, 32'h0000_3068, 32'h0000_3020,32'h0000_305C,0, 0);
      tv[34] = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        1, 0, 1, 32'h0000_4180, 32'h0000_3068,32'h0000_305C,0, 0);
      tv[35] = mk(1, 3, 0, 16'h0,    26'h0,       32'hFFFF_FFFF,0, 0, 0, 32'hFFFF_FFFC, 32'h0000_3068,32'h0000_305C,0, 0);
      tv[36] = mk(1, 0, 0, 16'h0,    26'h0,       32'h0,        0, 0, 0, 32'h0000_0000, 32'h0000_3068,32'h0000_305C,0, 0);
      tv[37] = mk(1, 3, 0, 16'h0,    26'h0,       32'hA000_0000,0, 0, 0, 32'hA000_0000, 32'h0000_3068,32'h0000_305C,0, 0);
      tv[38] = mk(1, 2, 0, 16'h0,    26'h3FFFFFF, 32'h0,        0, 0, 0, 32'hAFFF_FFFC, 32'h0000_3068,32'h0000_305C,0, 0);

      rst_n = 1'b0;
      PCWr = 1'b0; NPCOp = 3'd0; br_taken = 1'b0; imm16 = '0; j_index = '0;
      jr_target = '0; exc_req = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk_all(-1, 32'h0000_3000, 32'h0, 32'h0, 1'b1, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         drive(tv[i]);
         @(posedge clk);
         #1;
         chk_all(i, tv[i].e_pc, tv[i].e_epc, tv[i].e_top, tv[i].e_empty, tv[i].e_full);
         @(negedge clk);
      end

      // Mid-cycle asynchronous reset with a live EPC and a non-empty RAS.
      drive(mk(1, 0, 0, 16'h0, 26'h0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 0, 0));
      #2;
      rst_n = 1'b0;
      #1;
      chk_all(100, 32'h0000_3000, 32'h0, 32'h0, 1'b1, 1'b0);

      // Held reset wins over PCWr and ras_push at a clock edge.
      @(posedge clk);
      #1;
      chk_all(101, 32'h0000_3000, 32'h0, 32'h0, 1'b1, 1'b0);

      // First edge after release performs a normal update.
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_all(102, 32'h0000_3004, 32'h0, 32'h0000_3004, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
